// File: rtl/univ_shift_seq_if.sv
// Command channel of the universal shift sequencer: valid/ready handshake plus op, count,
// parallel data and serial-in bit.
interface univ_shift_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_sin;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        output cmd_data,
        output cmd_sin,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        input  cmd_data,
        input  cmd_sin,
        output cmd_ready
    );
endinterface

// File: rtl/univ_shift_seq.sv
// Universal 4-bit shift register driven by a 4-deep command FIFO; each command is popped,
// fetched and executed for cnt cycles (LOAD always one) before a one-cycle done pulse.
module univ_shift_seq (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    univ_shift_seq_if.slave        cmd,
    output logic [1:0]             mode_o,
    output logic [3:0]             q_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2:0]             fifo_level_o
);

    localparam logic [1:0] OpHold = 2'b00;
    localparam logic [1:0] OpShr  = 2'b01;
    localparam logic [1:0] OpShl  = 2'b10;
    localparam logic [1:0] OpLoad = 2'b11;

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

    state_e state_q, state_d;
    logic   busy_q;

    logic [10:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  level_q;

    logic [1:0] op_q;
    logic [3:0] cnt_q, data_q, rem_q, sh_q;
    logic       sin_q;

    logic        push, pop;
    logic [10:0] head;

    assign cmd.cmd_ready = !rst_i && !flush_i && (level_q != 3'd4);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state_q == StIdle) && (level_q != 3'd0) && !flush_i;
    assign head          = fifo_q[rd_ptr_q];

    // State register; busy is registered from the next-state decode so it tracks state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (level_q != 3'd0) state_d = StFetch;
            StFetch: state_d = StExec;
            StExec:  if (rem_q == 4'd1) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        mode_o       = (state_q == StExec) ? op_q : OpHold;
        done_o       = (state_q == StDone);
        busy_o       = busy_q;
        q_o          = sh_q;
        fifo_level_o = level_q;
    end

    // Storage only; push is already gated by reset and flush through cmd_ready.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_cnt, cmd.cmd_data, cmd.cmd_sin};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 3'd0;
            sh_q     <= 4'd0;
            op_q     <= OpHold;
            cnt_q    <= 4'd0;
            data_q   <= 4'd0;
            sin_q    <= 1'b0;
            rem_q    <= 4'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 3'd1;
                2'b01:   level_q <= level_q - 3'd1;
                default: level_q <= level_q;
            endcase

            if (pop) begin
                // A zero-count command degenerates to a single HOLD cycle.
                op_q   <= (head[8:5] == 4'd0) ? OpHold : head[10:9];
                cnt_q  <= head[8:5];
                data_q <= head[4:1];
                sin_q  <= head[0];
            end

            if (state_q == StFetch) begin
                rem_q <= ((cnt_q == 4'd0) || (op_q == OpLoad)) ? 4'd1 : cnt_q;
            end

            if (state_q == StExec) begin
                rem_q <= rem_q - 4'd1;
                unique case (op_q)
                    OpHold: sh_q <= sh_q;
                    OpShr:  sh_q <= {sin_q, sh_q[3:1]};
                    OpShl:  sh_q <= {sh_q[2:0], sin_q};
                    OpLoad: sh_q <= data_q;
                    default: sh_q <= sh_q;
                endcase
            end
        end
    end

endmodule
